// File: rtl/instru_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: loader side; slave: byte source / memory side.
interface instru_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instru_loader.sv
// Boot loader: big-endian length + word stream into instruction memory, holds the CPU until loaded.
// Optional LOADER_CHECKSUM_EN: trailing XOR checksum byte replaces the FLUSH cycle with CSUM.
module instru_loader #(
    parameter int unsigned MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    instru_loader_if.master bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            err
);

    localparam logic [2:0] LEN_HI = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] CSUM   = 3'd6;
`else
    localparam logic [2:0] FLUSH  = 3'd3;
`endif
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [2:0] ERR    = 3'd5;

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] shift_reg;
    logic [15:0] n_len;
    logic        ready;
    logic        take;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    always_comb begin
        ready = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CSUM:                 ready = 1'b1;
`endif
            default:              ready = 1'b0;
        endcase
    end

    assign bus.in_ready = ready;
    assign take         = ready & bus.in_valid;
    assign n_len        = {len[15:8], bus.in_data};
    assign cpu_hold     = (state != DONE);
    assign done         = (state == DONE);
    assign err          = (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LEN_HI;
            len          <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            shift_reg    <= '0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= BASE_ADDR;
            bus.im_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            bus.im_we <= 1'b0;
            case (state)
                LEN_HI: begin
                    if (take) begin
                        len[15:8] <= bus.in_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        len[7:0] <= bus.in_data;
                        if (n_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
`endif
                        end else if (32'(n_len) > MEM_WORDS) begin
                            state <= ERR;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        shift_reg <= {shift_reg[23:0], bus.in_data};
                        byte_cnt  <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= csum ^ bus.in_data;
`endif
                        // Fourth byte completes a word: write it while still accepting bytes.
                        if (byte_cnt == 2'd3) begin
                            bus.im_we    <= 1'b1;
                            bus.im_wdata <= {shift_reg[23:0], bus.in_data};
                            bus.im_addr  <= BASE_ADDR + {14'b0, word_cnt, 2'b00};
                            word_cnt     <= word_cnt + 16'd1;
                            if (word_cnt == len - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= CSUM;
`else
                                state <= FLUSH;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CSUM: begin
                    if (take) begin
                        state <= (csum == bus.in_data) ? DONE : ERR;
                    end
                end
`else
                FLUSH: begin
                    state <= DONE;
                end
`endif
                DONE, ERR: begin
                    if (start) begin
                        state       <= LEN_HI;
                        len         <= '0;
                        word_cnt    <= '0;
                        byte_cnt    <= '0;
                        shift_reg   <= '0;
                        bus.im_addr <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        csum        <= '0;
`endif
                    end
                end
                default: begin
                    state <= LEN_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instru_loader.sv
// Self-checking bench for instru_loader: directed test-plan streams plus random images,
// checked against a stream-level model of the expected memory writes and final status.
module tb_instru_loader;
    localparam int unsigned MEM_WORDS = 64;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, done, err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    instru_loader_if bus();

    instru_loader #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: every im_we pulse must match the next expected word.
    always @(posedge clk) begin
        #1;
        if (!rst) check("done_err_exclusive", {31'b0, done & err}, 32'd0);
        if (bus.im_we === 1'b1) begin
            total++;
            assert (exp_addr.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_we got addr=%h data=%h exp=no write", bus.im_addr, bus.im_wdata);
            end
            if (exp_addr.size() != 0) begin
                check("we_addr", bus.im_addr, exp_addr.pop_front());
                check("we_data", bus.im_wdata, exp_data.pop_front());
            end
        end
    end

    // Stream-level model: decide how many bytes get consumed, what gets written, and the outcome.
    function automatic void model(input bq_t img, output int used, output logic exp_done);
        int n;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        n = int'({img[0], img[1]});
        if (n > int'(MEM_WORDS)) begin
            used = 2;
            exp_done = 1'b0;
            return;
        end
        used = 2 + 4 * n;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(BASE + 32'(4 * i));
            exp_data.push_back({img[2 + 4*i], img[3 + 4*i], img[4 + 4*i], img[5 + 4*i]});
        end
`ifdef LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int j = 2; j < used; j++) x = x ^ img[j];
        exp_done = (img[used] == x);
        used = used + 1;
`else
        exp_done = 1'b1;
`endif
    endfunction

    function automatic bq_t with_csum(input bq_t q);
        bq_t r;
        logic [7:0] x;
        r = q;
        x = 8'h00;
        for (int i = 2; i < q.size(); i++) x = x ^ q[i];
        r.push_back(x);
        return r;
    endfunction

    function automatic bq_t make_img(input int n, input logic corrupt);
        bq_t q;
        logic [7:0] b;
        logic [7:0] x;
        int nd;
        x = 8'h00;
        nd = (n > int'(MEM_WORDS)) ? 0 : 4 * n;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        for (int i = 0; i < nd; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x = x ^ b;
        end
        q.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
        return q;
    endfunction

    task automatic push_byte(input logic [7:0] b, input int gap);
        int   w;
        logic acc;
        w = 0;
        acc = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        do begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            w++;
        end while (!acc && w < 20);
        bus.in_valid = 1'b0;
        total++;
        assert (acc) else begin
            bad++;
            $error("FAIL accept_timeout got=not accepted exp=accepted byte=%h", b);
        end
    endtask

    task automatic run_image(input string tag, input bq_t img, input int gap_lo, input int gap_hi);
        int   used;
        int   n;
        int   lat;
        int   exp_lat;
        logic exp_done;
        n = int'({img[0], img[1]});
        model(img, used, exp_done);
        for (int i = 0; i < used; i++)
            push_byte(img[i], int'($urandom_range(gap_hi, gap_lo)));
        lat = 0;
        while (!(done | err) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
`ifdef LOADER_CHECKSUM_EN
        exp_lat = 0;
`else
        exp_lat = (n > 0 && n <= int'(MEM_WORDS)) ? 1 : 0;
`endif
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
        check({tag, "_err"}, {31'b0, err}, {31'b0, !exp_done});
        check({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, !exp_done});
        // Bytes offered after completion must be refused.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (3) begin
            @(posedge clk); #1;
            check({tag, "_ready_after"}, {31'b0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        check({tag, "_status_kept"}, {30'b0, done, err}, {30'b0, exp_done, !exp_done});
        check({tag, "_writes_left"}, 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {31'b0, bus.in_ready}, 32'd1);
        check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd1);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_we"}, {31'b0, bus.im_we}, 32'd0);
        check({tag, "_addr"}, bus.im_addr, BASE);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_idle("start");
    endtask

    initial begin
        bq_t q;
        int  used;
        logic exp_done;
        int  n;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset");
        check("reset_wdata", bus.im_wdata, 32'd0);

        // Normal load, back-to-back bytes.
        q = with_csum('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08});
        run_image("normal", q, 0, 0);
        pulse_start();

        // Same stream with in_valid gaps of two cycles.
        run_image("gapped", q, 2, 2);
        pulse_start();

        // Oversize length, then recovery with a one-word image.
        run_image("oversize", with_csum('{8'h00, 8'h41}), 0, 0);
        pulse_start();
        run_image("recover", with_csum('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}), 0, 1);
        pulse_start();

        // Zero-length image.
        run_image("zero", with_csum('{8'h00, 8'h00}), 0, 0);
        pulse_start();

        // Largest legal image: last write lands at BASE + 4*(MEM_WORDS-1).
        run_image("full", make_img(int'(MEM_WORDS), 1'b0), 0, 0);
        pulse_start();

        // Reset partway through the second word.
        q = with_csum('{8'h00, 8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2,
                        8'hB3, 8'hB4, 8'hC1, 8'hC2, 8'hC3, 8'hC4});
        model(q, used, exp_done);
        for (int i = 0; i < 8; i++) push_byte(q[i], 0);
        @(posedge clk); #1;
        check("midrst_words_left", 32'(exp_addr.size()), 32'd2);
        exp_addr.delete();
        exp_data.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("midrst");
        check("midrst_wdata", bus.im_wdata, 32'd0);
        run_image("after_rst", with_csum('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44}), 0, 0);
        pulse_start();

`ifdef LOADER_CHECKSUM_EN
        run_image("csum_ok", '{8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F}, 0, 0);
        pulse_start();
        run_image("csum_bad", '{8'h00, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E}, 0, 0);
        pulse_start();
        run_image("csum_zero_bad", '{8'h00, 8'h00, 8'h5A}, 0, 0);
        pulse_start();
`endif

        // Random images: mostly small, occasionally oversize, random gaps.
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(4, 0) == 0)
                n = int'(MEM_WORDS) + int'($urandom_range(200, 1));
            else
                n = int'($urandom_range(8, 0));
            run_image("rand", make_img(n, ($urandom_range(3, 0) == 0)), 0, 3);
            pulse_start();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
